// File: rtl/bank_stream_reader.sv
// Drains one bank of the banked shared memory as a valid/ready word stream.
// Define BANK_READER_AUTOADVANCE_EN to keep streaming into following banks until stop_req.
module bank_stream_reader #(
   parameter int no_banks      = 8,
   parameter int word_width    = 4,
   parameter int address_width = 5,
   localparam int bank_w       = (no_banks > 1) ? $clog2(no_banks) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [bank_w-1:0]        start_bank,
   output logic [no_banks-1:0]      rd_bank_select,
   output logic [address_width-1:0] rd_address,
   input  logic [word_width-1:0]    rd_data,
   output logic [word_width-1:0]    out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
`ifdef BANK_READER_AUTOADVANCE_EN
   input  logic                     stop_req,
`endif
   output logic                     busy,
   output logic                     err
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                   state_q, state_d;
   logic [bank_w-1:0]        bank_q, bank_d;
   logic [address_width-1:0] addr_q, addr_d;
   logic                     inflight_q, inflight_d;
   logic                     inflight_last_q, inflight_last_d;
   logic                     err_q, err_d;
   logic [word_width-1:0]    fifo_data_q [2];
   logic [1:0]               fifo_last_q;
   logic                     wr_ptr_q, rd_ptr_q;
   logic [1:0]               count_q;

   logic       pop, head_last, accept, issue, last_addr, flush;
   logic [1:0] occ;

   assign pop       = (count_q != 2'd0) && out_ready;
   assign head_last = fifo_last_q[rd_ptr_q];
   assign accept    = start && (state_q == IDLE) &&
                      ({1'b0, start_bank} < (bank_w + 1)'(no_banks));
   assign last_addr = (addr_q == {address_width{1'b1}});
   // Occupancy net of this cycle's transfer and capture keeps one read per cycle
   // flowing without ever overfilling the two-entry buffer.
   assign occ       = count_q - {1'b0, pop} + {1'b0, inflight_q};
   assign issue     = (state_q == READ) && (occ < 2'd2);

   always_comb begin
      state_d         = state_q;
      bank_d          = bank_q;
      addr_d          = addr_q;
      inflight_d      = issue;
      inflight_last_d = issue && last_addr;
      err_d           = start && !accept;
      flush           = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = READ;
               bank_d  = start_bank;
               addr_d  = '0;
            end
         end
         READ: begin
            if (issue) begin
               addr_d = addr_q + 1'b1;
               if (last_addr) begin
`ifdef BANK_READER_AUTOADVANCE_EN
                  bank_d = (bank_q == bank_w'(no_banks - 1)) ? '0 : bank_q + 1'b1;
`else
                  state_d = DRAIN;
`endif
               end
            end
`ifdef BANK_READER_AUTOADVANCE_EN
            // Words already fetched from the next bank are discarded on stop.
            if (pop && head_last && stop_req) begin
               state_d         = IDLE;
               addr_d          = '0;
               inflight_d      = 1'b0;
               inflight_last_d = 1'b0;
               flush           = 1'b1;
            end
`endif
         end
         DRAIN: begin
            if (pop && head_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         bank_q          <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         err_q           <= 1'b0;
         count_q         <= 2'd0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         bank_q          <= bank_d;
         addr_q          <= addr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         err_q           <= err_d;
         count_q         <= flush ? 2'd0 : occ;
         wr_ptr_q        <= flush ? 1'b0 : (wr_ptr_q ^ inflight_q);
         rd_ptr_q        <= flush ? 1'b0 : (rd_ptr_q ^ pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_last_q    <= 2'b00;
      end else if (inflight_q && !flush) begin
         fifo_data_q[wr_ptr_q] <= rd_data;
         fifo_last_q[wr_ptr_q] <= inflight_last_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < no_banks; gi++) begin : g_sel
         assign rd_bank_select[gi] = (state_q != IDLE) && (bank_q == bank_w'(gi));
      end
   endgenerate

   assign rd_address = addr_q;
   assign out_valid  = (count_q != 2'd0);
   assign out_data   = fifo_data_q[rd_ptr_q];
   assign out_last   = out_valid && head_last;
   assign busy       = (state_q != IDLE);
   assign err        = err_q;

endmodule
